updi_rx_frame_decoder: RTL and testbench

//  Receive-side counterpart of the UPDI command generator. Takes 12-bit frames from the RX PHY

---
 rtl/updi_rx_frame_decoder_pkg.sv | 50 +++++
 rtl/updi_rx_frame_decoder_if.sv | 31 +++
 rtl/updi_rx_frame_decoder_fifo.sv | 72 +++++++
 rtl/updi_rx_frame_decoder.sv | 193 +++++++++++++++++++
 tb/tb_updi_rx_frame_decoder.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/updi_rx_frame_decoder_pkg.sv
// Shared definitions for the UPDI receive path: frame layout, receiver states,
// error codes and the frame check helpers.
package updi_rx_frame_decoder_pkg;

  localparam int FRAME_W   = 12;
  localparam int START_BIT = 11;
  localparam int DATA_MSB  = 10;
  localparam int DATA_LSB  = 3;
  localparam int PAR_BIT   = 2;
  localparam int STOP_MSB  = 1;
  localparam int STOP_LSB  = 0;
  localparam logic [1:0] STOP_PATTERN = 2'b11;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_ECHO    = 3'd1,
    RX_COLLECT = 3'd2,
    RX_DONE    = 3'd3,
    RX_ERROR   = 3'd4
  } rx_state_e;

  // Also consumed by the command generator status path.
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_START    = 3'd1,
    ERR_STOP     = 3'd2,
    ERR_PARITY   = 3'd3,
    ERR_TIMEOUT  = 3'd4,
    ERR_OVERFLOW = 3'd5
  } err_code_e;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  function automatic err_code_e frame_check(input logic [FRAME_W-1:0] frame);
    err_code_e code;
    if (frame[START_BIT]) begin
      code = ERR_START;
    end else if (frame[STOP_MSB:STOP_LSB] != STOP_PATTERN) begin
      code = ERR_STOP;
    end else if (frame[PAR_BIT] != even_parity(frame[DATA_MSB:DATA_LSB])) begin
      code = ERR_PARITY;
    end else begin
      code = ERR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/updi_rx_frame_decoder_if.sv
// Bundle of the RX PHY frame input, the controller handshake and the response
// byte stream of the UPDI frame decoder.
interface updi_rx_frame_decoder_if #(
  parameter int CNT_W = 10
);
  import updi_rx_frame_decoder_pkg::*;

  logic                 i_arm;
  logic [CNT_W-1:0]     i_echo_cnt;
  logic [CNT_W-1:0]     i_resp_cnt;
  logic [FRAME_W-1:0]   i_frame;
  logic                 i_frame_valid;
  logic [7:0]           o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;
  err_code_e            o_err_code;

  modport slave (
    input  i_arm, i_echo_cnt, i_resp_cnt, i_frame, i_frame_valid, i_ready,
    output o_data, o_valid, o_busy, o_done, o_err, o_err_code
  );

  modport master (
    output i_arm, i_echo_cnt, i_resp_cnt, i_frame, i_frame_valid, i_ready,
    input  o_data, o_valid, o_busy, o_done, o_err, o_err_code
  );

endinterface

// File: rtl/updi_rx_frame_decoder_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; a push into a full FIFO
// is accepted only when a pop happens on the same cycle.
module updi_rx_frame_decoder_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  logic full_s;
  logic empty_s;
  logic pop_ok_s;
  logic push_ok_s;

  assign full_s    = (count_q == FULL_CNT);
  assign empty_s   = (count_q == '0);
  assign pop_ok_s  = pop_i && !empty_s;
  assign push_ok_s = push_i && (!full_s || pop_ok_s);

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_s;
  assign empty_o = empty_s;

endmodule

// File: rtl/updi_rx_frame_decoder.sv
// UPDI receive frame decoder: checks PHY frames, drops the half-duplex echo and
// queues the target response bytes, reporting done / error / timeout.
module updi_rx_frame_decoder
  import updi_rx_frame_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  updi_rx_frame_decoder_if.slave   bus
);

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  rx_state_e        state_q;
  logic [CNT_W-1:0] echo_q;
  logic [CNT_W-1:0] resp_q;
  logic [TMR_W-1:0] timer_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  err_code_e        code_q;

  logic             chk_valid_q;
  logic [7:0]       chk_data_q;
  err_code_e        chk_code_q;

  err_code_e        frame_code_s;
  logic             active_s;
  logic             chk_good_s;
  logic             pop_s;
  logic             overflow_s;
  logic             push_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [7:0]       fifo_rdata_s;
  logic             flush_s;

  assign frame_code_s = frame_check(bus.i_frame);
  assign active_s     = (state_q == RX_ECHO) || (state_q == RX_COLLECT);
  assign chk_good_s   = chk_valid_q && (chk_code_q == ERR_NONE);
  assign pop_s        = !fifo_empty_s && bus.i_ready;
  assign overflow_s   = chk_good_s && (state_q == RX_COLLECT) && fifo_full_s && !pop_s;
  assign push_s       = chk_good_s && (state_q == RX_COLLECT) && !overflow_s;
  // Arm is only honoured in IDLE/ERROR, where incoming frames are ignored anyway.
  assign flush_s      = bus.i_arm && ((state_q == RX_IDLE) || (state_q == RX_ERROR));

  // Check stage: frames only enter while a transaction is listening.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      chk_valid_q <= 1'b0;
      chk_data_q  <= 8'h00;
      chk_code_q  <= ERR_NONE;
    end else begin
      chk_valid_q <= bus.i_frame_valid && active_s;
      chk_data_q  <= bus.i_frame[DATA_MSB:DATA_LSB];
      chk_code_q  <= frame_code_s;
    end
  end

  // Transaction FSM with its counters, timeout timer and status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RX_IDLE;
      echo_q  <= '0;
      resp_q  <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RX_IDLE, RX_ERROR: begin
          if (bus.i_arm) begin
            echo_q  <= bus.i_echo_cnt;
            resp_q  <= bus.i_resp_cnt;
            timer_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            if (bus.i_echo_cnt != '0) begin
              state_q <= RX_ECHO;
              busy_q  <= 1'b1;
            end else if (bus.i_resp_cnt != '0) begin
              state_q <= RX_COLLECT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= RX_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= state_q;
          end
        end
        RX_ECHO: begin
          if (chk_valid_q && !chk_good_s) begin
            state_q <= RX_ERROR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            code_q  <= chk_code_q;
          end else if (chk_good_s) begin
            timer_q <= '0;
            if (echo_q > CNT_W'(1)) begin
              echo_q <= echo_q - CNT_W'(1);
            end else begin
              echo_q <= '0;
              if (resp_q != '0) begin
                state_q <= RX_COLLECT;
              end else begin
                state_q <= RX_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end else if (timer_q == TMR_LAST) begin
            state_q <= RX_ERROR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            code_q  <= ERR_TIMEOUT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        RX_COLLECT: begin
          if (chk_valid_q && !chk_good_s) begin
            state_q <= RX_ERROR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            code_q  <= chk_code_q;
          end else if (overflow_s) begin
            state_q <= RX_ERROR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            code_q  <= ERR_OVERFLOW;
          end else if (chk_good_s) begin
            timer_q <= '0;
            if (resp_q > CNT_W'(1)) begin
              resp_q <= resp_q - CNT_W'(1);
            end else begin
              resp_q  <= '0;
              state_q <= RX_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (timer_q == TMR_LAST) begin
            state_q <= RX_ERROR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            code_q  <= ERR_TIMEOUT;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        RX_DONE: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= RX_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  updi_rx_frame_decoder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .flush_i (flush_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (chk_data_q),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Masked so o_data reads zero, not stale storage, when nothing is queued.
  assign bus.o_data     = fifo_empty_s ? 8'h00 : fifo_rdata_s;
  assign bus.o_valid    = !fifo_empty_s;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;
  assign bus.o_err_code = code_q;

endmodule

// File: tb/tb_updi_rx_frame_decoder.sv
// Scoreboard bench for the UPDI RX frame decoder: directed scenarios plus
// randomized transactions against a frame-level reference model.
module tb_updi_rx_frame_decoder;
  import updi_rx_frame_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  updi_rx_frame_decoder_if bus ();

  updi_rx_frame_decoder dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int rdy_mode = 1;
  logic [7:0] exp_q[$];
  logic [7:0] tx_data[$];
  logic [7:0] mon_exp;

  // Downstream ready: 0 = stalled, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) bus.i_ready = 1'b0;
    else if (rdy_mode == 1) bus.i_ready = 1'b1;
    else bus.i_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: every popped byte is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.o_done === 1'b1) done_seen++;
    if (!rst && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL data: got byte %02h, expected no byte", bus.o_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.o_data !== mon_exp) begin
          bad++;
          $display("FAIL data: got %02h expected %02h", bus.o_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] mk_frame(input logic [7:0] d);
    return {1'b0, d, ^d, 2'b11};
  endfunction

  // Reference decision for one frame: 0 good, 1 start, 2 stop, 3 parity.
  function automatic int model_code(input logic [11:0] f);
    int v;
    v = int'(f);
    if (((v >> 11) & 1) != 0) return 1;
    if ((v & 3) != 3) return 2;
    if (($countones(f[10:3]) % 2) != ((v >> 2) & 1)) return 3;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic do_arm(input int e, input int r, input bit fv, input logic [11:0] f);
    @(posedge clk); #1;
    bus.i_arm = 1'b1;
    bus.i_echo_cnt = e[9:0];
    bus.i_resp_cnt = r[9:0];
    bus.i_frame = f;
    bus.i_frame_valid = fv;
    @(posedge clk); #1;
    bus.i_arm = 1'b0;
    bus.i_frame_valid = 1'b0;
  endtask

  task automatic send(input logic [11:0] f, input int gap);
    bus.i_frame = f;
    bus.i_frame_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_frame_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string nm);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  // One transaction: echo frames, then response frames; frame bad_idx gets xr applied.
  task automatic run_txn(input string nm, input int e, input int r, input int bad_idx, input logic [11:0] xr);
    int d0;
    int code;
    int exp_code;
    logic [11:0] f;
    exp_code = 0;
    d0 = done_seen;
    do_arm(e, r, 1'b0, 12'h000);
    for (int i = 0; i < e + r; i++) begin
      f = mk_frame(tx_data[i]);
      if (i == bad_idx) f = f ^ xr;
      code = model_code(f);
      if (code == 0 && i >= e) exp_q.push_back(f[10:3]);
      send(f, $urandom_range(0, 2));
      if (code != 0) begin
        exp_code = code;
        break;
      end
    end
    repeat (4) @(negedge clk);
    chk({nm, "_err"}, bus.o_err, (exp_code != 0) ? 1 : 0);
    chk({nm, "_code"}, bus.o_err_code, exp_code);
    chk({nm, "_done"}, done_seen - d0, (exp_code == 0) ? 1 : 0);
    chk({nm, "_busy"}, bus.o_busy, 0);
    wait_drain({nm, "_drain"});
  endtask

  initial begin
    int w;
    int cnt;
    int e;
    int r;
    int bidx;
    logic [7:0] d;
    bus.i_arm = 1'b0;
    bus.i_echo_cnt = '0;
    bus.i_resp_cnt = '0;
    bus.i_frame = 12'h000;
    bus.i_frame_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_code", bus.o_err_code, 0);
    chk("rst_data", bus.o_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Echo of two frames dropped, one response byte delivered.
    rdy_mode = 1;
    tx_data = '{8'h55, 8'h55, 8'h40};
    run_txn("t1", 2, 1, -1, 12'h000);

    // Parity flipped on the only response frame.
    tx_data = '{8'h40};
    run_txn("t2", 0, 1, 0, 12'h004);
    chk("t2_valid", bus.o_valid, 0);

    // One byte then silence: timeout a full TIMEOUT_CYC after the byte lands.
    rdy_mode = 0;
    do_arm(0, 2, 1'b0, 12'h000);
    exp_q.push_back(8'h5A);
    send(mk_frame(8'h5A), 0);
    w = 0;
    while (bus.o_valid !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("t3_valid", bus.o_valid, 1);
    cnt = 0;
    while (bus.o_err !== 1'b1 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    chk("t3_timeout_cycles", cnt, 4096);
    chk("t3_code", bus.o_err_code, 4);
    chk("t3_held", bus.o_valid, 1);
    chk("t3_busy", bus.o_busy, 0);
    rdy_mode = 1;
    wait_drain("t3_drain");

    // Nine bytes into an eight-deep stalled FIFO.
    rdy_mode = 0;
    do_arm(0, 9, 1'b0, 12'h000);
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < 8) exp_q.push_back(d);
      send(mk_frame(d), 0);
    end
    repeat (4) @(negedge clk);
    chk("t4_err", bus.o_err, 1);
    chk("t4_code", bus.o_err_code, 5);
    chk("t4_valid", bus.o_valid, 1);
    rdy_mode = 1;
    wait_drain("t4_drain");
    @(negedge clk);
    chk("t4_empty", bus.o_valid, 0);

    // Asynchronous reset in the middle of collecting.
    rdy_mode = 0;
    do_arm(0, 5, 1'b0, 12'h000);
    for (int i = 0; i < 3; i++) send(mk_frame(8'(8'h10 + i)), 0);
    repeat (3) @(negedge clk);
    chk("t5_busy_before", bus.o_busy, 1);
    chk("t5_valid_before", bus.o_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid_rst", bus.o_valid, 0);
    chk("t5_busy_rst", bus.o_busy, 0);
    chk("t5_err_rst", bus.o_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy", bus.o_busy, 0);
    chk("t5_idle_valid", bus.o_valid, 0);
    rdy_mode = 1;

    // Empty transaction, then arm with a simultaneous frame that must be dropped.
    do_arm(0, 0, 1'b0, 12'h000);
    @(negedge clk);
    chk("t6_done_pulse", bus.o_done, 1);
    @(negedge clk);
    chk("t6_done_clear", bus.o_done, 0);
    cnt = done_seen;
    do_arm(0, 1, 1'b1, mk_frame(8'hA5));
    exp_q.push_back(8'h3C);
    send(mk_frame(8'h3C), 0);
    repeat (4) @(negedge clk);
    chk("t6_arm_frame_done", done_seen - cnt, 1);
    chk("t6_arm_frame_err", bus.o_err, 0);
    wait_drain("t6_drain");

    // Randomized transactions with random ready and occasional corrupted frames.
    rdy_mode = 2;
    for (int t = 0; t < 24; t++) begin
      e = $urandom_range(0, 3);
      r = $urandom_range(0, 5);
      tx_data.delete();
      for (int i = 0; i < e + r; i++) tx_data.push_back(8'($urandom_range(0, 255)));
      bidx = -1;
      if (e + r > 0 && $urandom_range(0, 2) == 0) bidx = $urandom_range(0, e + r - 1);
      run_txn("rnd", e, r, bidx, 12'($urandom_range(1, 4095)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
